// File: rtl/clint_bus_arbiter.sv
// Two-master Wishbone arbiter in front of the CLINT slave port.
// Round-robin grant held per bus cycle, with a per-transfer ack timeout.
module clint_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_stb_i,
  input  logic            m0_cyc_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_stb_i,
  input  logic            m1_cyc_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_stb_o,
  output logic            s_cyc_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      gnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1,
    ABORT
  } state_e;

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          ab_q, ab_d;
  logic [CW-1:0] tmr_q, tmr_d;

  logic own0, own1, own;
  logic own_cyc, to_hit;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);
  assign own  = own0 | own1;

  assign s_adr_o = own1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = own1 ? m1_dat_i : m0_dat_i;
  assign s_sel_o = own1 ? m1_sel_i : m0_sel_i;
  assign s_we_o  = (own0 & m0_we_i)  | (own1 & m1_we_i);
  assign s_stb_o = (own0 & m0_stb_i) | (own1 & m1_stb_i);
  assign s_cyc_o = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);

  assign own_cyc = own1 ? m1_cyc_i : m0_cyc_i;
  assign to_hit  = own & s_cyc_o & s_stb_o & ~s_ack_i
                 & (tmr_q == TO_LAST);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = own0 & s_ack_i;
  assign m1_ack_o = own1 & s_ack_i;
  assign m0_err_o = own0 & to_hit;
  assign m1_err_o = own1 & to_hit;
  assign gnt_o    = {own1, own0};

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ab_d    = ab_q;
    tmr_d   = '0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (m0_cyc_i & m1_cyc_i): begin
            state_d = last_q ? OWN0 : OWN1;
            last_d  = ~last_q;
          end
          (m0_cyc_i & ~m1_cyc_i): begin
            state_d = OWN0;
            last_d  = 1'b0;
          end
          (m1_cyc_i & ~m0_cyc_i): begin
            state_d = OWN1;
            last_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
      OWN0, OWN1: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (to_hit) begin
          state_d = ABORT;
          ab_d    = own1;
        end else if (s_stb_o && !s_ack_i) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ABORT: begin
        // stay gated until the aborted master gives up its cycle
        if (!(ab_q ? m1_cyc_i : m0_cyc_i)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      ab_q    <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ab_q    <= ab_d;
      tmr_q   <= tmr_d;
    end
  end

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// Bench for clint_bus_arbiter: directed plan scenarios, then random
// traffic against a cycle-level reference model.
module tb_clint_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;
  localparam int CW = 5;
  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] m0_adr = '0, m1_adr = '0;
  logic [DW-1:0] m0_dat = '0, m1_dat = '0;
  logic [DW/8-1:0] m0_sel = '0, m1_sel = '0;
  logic m0_we = 0, m1_we = 0, m0_stb = 0, m1_stb = 0;
  logic m0_cyc = 0, m1_cyc = 0;
  logic [DW-1:0] m0_rd, m1_rd;
  logic m0_ack, m1_ack, m0_err, m1_err;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wd;
  logic [DW/8-1:0] s_sel;
  logic s_we, s_stb, s_cyc;
  logic [DW-1:0] s_rd = '0;
  logic s_ack = 0;
  logic [1:0] gnt;

  clint_bus_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
    .m0_we_i(m0_we), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
    .m0_dat_o(m0_rd), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
    .m1_we_i(m1_we), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
    .m1_dat_o(m1_rd), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_wd), .s_sel_o(s_sel),
    .s_we_o(s_we), .s_stb_o(s_stb), .s_cyc_o(s_cyc),
    .s_dat_i(s_rd), .s_ack_i(s_ack), .gnt_o(gnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: owner -1 none, 0/1 master; aborted marks a timed-out hold
  int  mo_owner = -1;
  bit  mo_abort = 0;
  int  mo_abm = 0;
  int  mo_last = 1;
  int  mo_wait = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cyc_of(int m);
    return (m == 1) ? m1_cyc : m0_cyc;
  endfunction

  function automatic bit stb_of(int m);
    return (m == 1) ? m1_stb : m0_stb;
  endfunction

  function automatic bit timeout_now();
    if (mo_owner < 0) return 0;
    return cyc_of(mo_owner) && stb_of(mo_owner) && !s_ack
           && (mo_wait == TIMEOUT - 1);
  endfunction

  task automatic compare_all();
    bit e_cyc, e_stb, e_we, to;
    logic [1:0] e_gnt;
    e_cyc = (mo_owner >= 0) ? cyc_of(mo_owner) : 1'b0;
    e_stb = (mo_owner >= 0) ? stb_of(mo_owner) : 1'b0;
    e_we = (mo_owner == 0) ? m0_we : (mo_owner == 1) ? m1_we : 1'b0;
    e_gnt = (mo_owner == 0) ? 2'b01 : (mo_owner == 1) ? 2'b10 : 2'b00;
    to = timeout_now();
    chk("gnt", gnt, e_gnt);
    chk("s_cyc", s_cyc, e_cyc);
    chk("s_stb", s_stb, e_stb);
    chk("s_we", s_we, e_we);
    chk("m0_ack", m0_ack, (mo_owner == 0) && s_ack);
    chk("m1_ack", m1_ack, (mo_owner == 1) && s_ack);
    chk("m0_err", m0_err, (mo_owner == 0) && to);
    chk("m1_err", m1_err, (mo_owner == 1) && to);
    chk("m0_rd", m0_rd, s_rd);
    chk("m1_rd", m1_rd, s_rd);
    if (mo_owner >= 0) begin
      chk("s_adr", s_adr, (mo_owner == 1) ? m1_adr : m0_adr);
      chk("s_wd", s_wd, (mo_owner == 1) ? m1_dat : m0_dat);
      chk("s_sel", s_sel, (mo_owner == 1) ? m1_sel : m0_sel);
    end
  endtask

  task automatic model_reset();
    mo_owner = -1;
    mo_abort = 0;
    mo_last = 1;
    mo_wait = 0;
  endtask

  task automatic model_update();
    bit to;
    if (!rst_n) begin
      model_reset();
      return;
    end
    to = timeout_now();
    if (mo_abort) begin
      if (!cyc_of(mo_abm)) mo_abort = 0;
    end else if (mo_owner < 0) begin
      mo_wait = 0;
      if (m0_cyc && m1_cyc) mo_owner = 1 - mo_last;
      else if (m0_cyc) mo_owner = 0;
      else if (m1_cyc) mo_owner = 1;
      if (mo_owner >= 0) mo_last = mo_owner;
    end else if (!cyc_of(mo_owner)) begin
      mo_owner = -1;
      mo_wait = 0;
    end else if (to) begin
      mo_abm = mo_owner;
      mo_abort = 1;
      mo_owner = -1;
      mo_wait = 0;
    end else if (stb_of(mo_owner) && !s_ack) begin
      mo_wait++;
    end else begin
      mo_wait = 0;
    end
  endtask

  task automatic settle();
    #3;
    compare_all();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle_all();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    s_ack = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_all();
    model_reset();
    tick();
    tick();
    rst_n = 1;
  endtask

  int a0, a1, nstb, erridx;

  initial begin
    idle_all();
    model_reset();
    @(posedge clk);
    #1;
    settle();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    advance();
    rst_n = 1;
    tick();

    // single M0 write
    m0_adr = CLINT_BASE + 32'h4000;
    m0_dat = 32'h0000_0100;
    m0_sel = 4'hf;
    m0_we = 1; m0_stb = 1; m0_cyc = 1;
    settle();
    chk("wr_lat_cyc0", s_cyc, 1'b0);
    advance();
    settle();
    chk("wr_cyc1", s_cyc, 1'b1);
    chk("wr_gnt", gnt, 2'b01);
    advance();
    s_ack = 1; s_rd = 32'hdead_beef;
    settle();
    chk("wr_ack0", m0_ack, 1'b1);
    chk("wr_ack1", m1_ack, 1'b0);
    advance();
    idle_all();
    settle();
    chk("wr_ack_pulse", m0_ack, 1'b0);
    advance();
    tick();

    // tie after reset, then alternate, then repeat tie
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    settle();
    chk("tie_first", gnt, 2'b01);
    advance();
    m0_cyc = 0; m0_stb = 0;
    tick();
    settle();
    chk("tie_gap", gnt, 2'b00);
    advance();
    settle();
    chk("tie_second", gnt, 2'b10);
    advance();
    m1_cyc = 0; m1_stb = 0;
    tick();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    settle();
    chk("tie_repeat", gnt, 2'b01);
    advance();
    idle_all();
    tick();
    tick();

    // M1 holds the bus for three reads while M0 waits
    m1_adr = CLINT_BASE + 32'hbff8;
    m1_cyc = 1; m1_stb = 1; m1_we = 0;
    tick();
    m0_cyc = 1; m0_stb = 1;
    a0 = 0; a1 = 0;
    for (int i = 0; i < 12; i++) begin
      s_ack = i[0];
      s_rd = $urandom;
      settle();
      if (m1_ack) a1++;
      if (m0_ack) a0++;
      advance();
      if (a1 == 3) break;
    end
    chk("hold_m1_acks", a1, 3);
    chk("hold_m0_acks", a0, 0);
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    tick();
    tick();
    s_ack = 1;
    settle();
    chk("hold_m0_after", m0_ack, 1'b1);
    advance();
    idle_all();
    tick();
    tick();

    // slave never acks
    m0_cyc = 1; m0_stb = 1;
    tick();
    nstb = 0; erridx = 0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (s_stb) nstb++;
      if (m0_err && erridx == 0) erridx = nstb;
      advance();
      if (erridx != 0) break;
    end
    chk("to_err_cycle", erridx, TIMEOUT);
    settle();
    chk("to_abort_cyc", s_cyc, 1'b0);
    chk("to_abort_err", m0_err, 1'b0);
    advance();
    s_ack = 1;
    settle();
    chk("to_late_ack", m0_ack, 1'b0);
    advance();
    idle_all();
    tick();
    m1_cyc = 1; m1_stb = 1;
    tick();
    settle();
    chk("to_next_gnt", gnt, 2'b10);
    advance();
    idle_all();
    tick();
    tick();

    // ack lands on the timeout threshold cycle
    m0_cyc = 1; m0_stb = 1;
    tick();
    for (int n = 1; n <= TIMEOUT; n++) begin
      s_ack = (n == TIMEOUT);
      settle();
      if (n == TIMEOUT) begin
        chk("thr_ack", m0_ack, 1'b1);
        chk("thr_err", m0_err, 1'b0);
      end
      advance();
    end
    s_ack = 0;
    settle();
    chk("thr_no_abort", s_cyc, 1'b1);
    advance();
    idle_all();
    tick();
    tick();

    // async reset in the middle of an M1 transfer
    m1_cyc = 1; m1_stb = 1;
    tick();
    s_ack = 1;
    settle();
    chk("rst_pre_ack", m1_ack, 1'b1);
    #1;
    rst_n = 0;
    #1;
    chk("rst_async_cyc", s_cyc, 1'b0);
    chk("rst_async_stb", s_stb, 1'b0);
    chk("rst_async_ack", m1_ack, 1'b0);
    chk("rst_async_gnt", gnt, 2'b00);
    model_reset();
    advance();
    tick();
    rst_n = 1;
    m0_cyc = 1; m1_cyc = 1; s_ack = 0;
    tick();
    settle();
    chk("rst_tie", gnt, 2'b01);
    advance();
    idle_all();
    tick();

    // random traffic, alternating responsive and silent slave phases
    for (int c = 0; c < 1200; c++) begin
      bit quiet;
      int drop;
      quiet = ((c / 80) % 2) == 1;
      drop = quiet ? 3 : 10;
      if (m0_cyc) m0_cyc = ($urandom_range(99) >= drop);
      else m0_cyc = ($urandom_range(99) < 15);
      if (m1_cyc) m1_cyc = ($urandom_range(99) >= drop);
      else m1_cyc = ($urandom_range(99) < 15);
      m0_stb = m0_cyc && ($urandom_range(3) != 0);
      m1_stb = m1_cyc && ($urandom_range(3) != 0);
      m0_we = $urandom_range(1);
      m1_we = $urandom_range(1);
      m0_adr = CLINT_BASE + ($urandom & 32'hfffc);
      m1_adr = CLINT_BASE + ($urandom & 32'hfffc);
      m0_dat = $urandom;
      m1_dat = $urandom;
      m0_sel = 4'($urandom);
      m1_sel = 4'($urandom);
      s_rd = $urandom;
      s_ack = quiet ? ($urandom_range(99) < 2) : ($urandom_range(2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
